// File: rtl/acc_dispatch_ctrl_if.sv
// Signal bundle between the core/accelerator side (master) and the dispatch
// controller (slave): job push handshake, issued-job bus and status.
interface acc_dispatch_ctrl_if #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = 8
);
  localparam int unsigned PW = $clog2(DEPTH);

  logic          cmd_valid;
  logic          cmd_ready;
  logic [31:0]   cmd_instr;
  logic [31:0]   cmd_startaddr;
  logic [31:0]   cmd_datasize;
  logic          cmd_bypass;
  logic          stall;

  logic [31:0]   fullinstructionA;
  logic [31:0]   startaddrA;
  logic [31:0]   datasizeA;
  logic          accbypassA;
  logic          accstart;
  logic          accdone;

  logic          busy;
  logic [PW:0]   pending;
  logic [CW-1:0] done_count;
  logic          timeout_err;

  modport master (
    output cmd_valid, cmd_instr, cmd_startaddr, cmd_datasize, cmd_bypass, accdone,
    input  cmd_ready, stall, fullinstructionA, startaddrA, datasizeA, accbypassA,
           accstart, busy, pending, done_count, timeout_err
  );

  modport slave (
    input  cmd_valid, cmd_instr, cmd_startaddr, cmd_datasize, cmd_bypass, accdone,
    output cmd_ready, stall, fullinstructionA, startaddrA, datasizeA, accbypassA,
           accstart, busy, pending, done_count, timeout_err
  );
endinterface

// File: rtl/acc_dispatch_ctrl.sv
// Accelerator job queue and sequencer: buffers core jobs in a FIFO and runs them one at a
// time (IDLE -> ISSUE -> WAIT -> RETIRE). Define ACC_TIMEOUT_EN to add the WAIT watchdog.
module acc_dispatch_ctrl #(
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned CW             = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               reset,
  acc_dispatch_ctrl_if.slave bus
);
  localparam int unsigned PW   = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RETIRE
  } state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] startaddr;
    logic [31:0] datasize;
    logic        bypass;
  } job_t;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("acc_dispatch_ctrl: DEPTH must be a power of two >= 2");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("acc_dispatch_ctrl: TIMEOUT_CYCLES must be >= 1");
  end

  state_e        state_q, state_d;
  job_t          mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  job_t          a_job_q, a_job_d;
  logic [CW-1:0] done_q, done_d;
  job_t          push_job;
  logic          cmd_ready;
  logic          push;
  logic          pop;
  logic          retire;
  logic          accstart;
  logic          tmo_hit;

  // Ready looks only at the registered count, so a full queue refuses a push even
  // when the sequencer pops in the same cycle.
  assign cmd_ready = (count_q != FULL);
  assign push      = bus.cmd_valid & cmd_ready;
  assign push_job  = '{instr:     bus.cmd_instr,
                       startaddr: bus.cmd_startaddr,
                       datasize:  bus.cmd_datasize,
                       bypass:    bus.cmd_bypass};

  // NOTE: the job storage has no reset; count_q guarantees an entry is written before it is read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_job;
    end
  end

  always_comb begin
    // NOTE: each always_comb output is defaulted first so no path can infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // ---------------------------------------------------------------- FSM
  // NOTE: flops are written with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (count_q != '0) state_d = ST_ISSUE;
      ST_ISSUE:  state_d = a_job_q.bypass ? ST_RETIRE : ST_WAIT;
      ST_WAIT:   if (bus.accdone || tmo_hit) state_d = ST_RETIRE;
      ST_RETIRE: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pop      = 1'b0;
    accstart = 1'b0;
    retire   = 1'b0;
    unique case (state_q)
      ST_IDLE:   pop      = (count_q != '0);
      ST_ISSUE:  accstart = ~a_job_q.bypass;
      ST_WAIT:   ;
      ST_RETIRE: retire   = 1'b1;
      default:   ;
    endcase
  end

  // ---------------------------------------------------------------- datapath
  always_comb begin
    a_job_d = pop ? mem_q[rd_ptr_q] : a_job_q;
    done_d  = retire ? done_q + 1'b1 : done_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      a_job_q  <= '0;
      done_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      a_job_q  <= a_job_d;
      done_q   <= done_d;
    end
  end

  // ---------------------------------------------------------------- watchdog
`ifdef ACC_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          tmo_err_q, tmo_err_d;

  // The counter holds the number of WAIT cycles already spent, so the limit is
  // reached on the TIMEOUT_CYCLES-th WAIT cycle; a same-cycle accdone still wins.
  assign tmo_hit = (state_q == ST_WAIT) && (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q == ST_ISSUE)     tmo_cnt_d = '0;
    else if (state_q == ST_WAIT) tmo_cnt_d = tmo_cnt_q + 1'b1;
    tmo_err_d = tmo_err_q | (tmo_hit & ~bus.accdone);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      tmo_cnt_q <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      tmo_err_q <= tmo_err_d;
    end
  end

  assign bus.timeout_err = tmo_err_q;
`else
  assign tmo_hit         = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

  // ---------------------------------------------------------------- outputs
  assign bus.cmd_ready        = cmd_ready;
  assign bus.stall            = bus.cmd_valid & ~cmd_ready;
  assign bus.fullinstructionA = a_job_q.instr;
  assign bus.startaddrA       = a_job_q.startaddr;
  assign bus.datasizeA        = a_job_q.datasize;
  assign bus.accbypassA       = a_job_q.bypass;
  assign bus.accstart         = accstart;
  assign bus.busy             = (state_q != ST_IDLE) || (count_q != '0);
  assign bus.pending          = count_q;
  assign bus.done_count       = done_q;
endmodule

// File: tb/tb_acc_dispatch_ctrl.sv
// Directed bench for acc_dispatch_ctrl: latency, backpressure, bypass, reset,
// done_count wrap and (when ACC_TIMEOUT_EN is defined) the WAIT watchdog.
module tb_acc_dispatch_ctrl;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = 8;

  logic clk;
  logic reset;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  acc_dispatch_ctrl_if #(.DEPTH(DEPTH), .CW(CW)) bus ();

  acc_dispatch_ctrl #(
    .DEPTH         (DEPTH),
    .CW            (CW),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "global timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Step to just after the next rising edge, where outputs are sampled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input logic v, input logic [31:0] instr, input logic [31:0] addr,
                         input logic [31:0] size, input logic byp);
    bus.cmd_valid     = v;
    bus.cmd_instr     = instr;
    bus.cmd_startaddr = addr;
    bus.cmd_datasize  = size;
    bus.cmd_bypass    = byp;
  endtask

  task automatic wait_accstart(input string tag);
    int n = 0;
    while (bus.accstart !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_seen"}, 32'(bus.accstart), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (bus.busy !== 1'b0 && n < 100) begin
      tick();
      n++;
    end
    check({tag, "_idle"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic push_bypass(input int n);
    int sent   = 0;
    int budget = 0;
    while (sent < n && budget < 5000) begin
      set_cmd(1'b1, 32'hB000_0000 + 32'(sent), 32'h0, 32'h0, 1'b1);
      #1;
      if (bus.cmd_ready === 1'b1) sent++;
      tick();
      budget++;
    end
    set_cmd(1'b0, '0, '0, '0, 1'b0);
    check("wrap_pushed", 32'(sent), 32'(n));
  endtask

  initial begin
    bus.accdone = 1'b0;
    set_cmd(1'b0, '0, '0, '0, 1'b0);
    reset = 1'b0;
    repeat (2) tick();

    // Reset state
    check("rst_pending",  32'(bus.pending), 32'd0);
    check("rst_busy",     32'(bus.busy), 32'd0);
    check("rst_accstart", 32'(bus.accstart), 32'd0);
    check("rst_done",     32'(bus.done_count), 32'd0);
    check("rst_ready",    32'(bus.cmd_ready), 32'd1);
    check("rst_instrA",   bus.fullinstructionA, 32'd0);
    check("rst_tmo",      32'(bus.timeout_err), 32'd0);
    reset = 1'b1;
    tick();

    // Single job: accepted cycle 0, issued cycle 2, accdone cycle 5, retired count at cycle 7
    set_cmd(1'b1, 32'h8C00_0001, 32'h40, 32'h10, 1'b0);
    #1;
    check("t1_ready", 32'(bus.cmd_ready), 32'd1);
    check("t1_stall", 32'(bus.stall), 32'd0);
    tick();
    set_cmd(1'b0, '0, '0, '0, 1'b0);
    check("t1_c1_pending",  32'(bus.pending), 32'd1);
    check("t1_c1_busy",     32'(bus.busy), 32'd1);
    check("t1_c1_accstart", 32'(bus.accstart), 32'd0);
    tick();
    check("t1_c2_accstart", 32'(bus.accstart), 32'd1);
    check("t1_c2_instrA",   bus.fullinstructionA, 32'h8C00_0001);
    check("t1_c2_addrA",    bus.startaddrA, 32'h40);
    check("t1_c2_sizeA",    bus.datasizeA, 32'h10);
    check("t1_c2_bypassA",  32'(bus.accbypassA), 32'd0);
    check("t1_c2_pending",  32'(bus.pending), 32'd0);
    tick();
    check("t1_c3_accstart", 32'(bus.accstart), 32'd0);
    tick();
    tick();
    bus.accdone = 1'b1;
    tick();
    bus.accdone = 1'b0;
    check("t1_c6_done", 32'(bus.done_count), 32'd0);
    tick();
    check("t1_c7_done",     32'(bus.done_count), 32'd1);
    check("t1_c7_busy",     32'(bus.busy), 32'd0);
    check("t1_c7_instrA",   bus.fullinstructionA, 32'h8C00_0001);

    // Backpressure: six jobs offered back-to-back, accdone held low
    tick();
    for (int i = 1; i <= 6; i++) begin
      set_cmd(1'b1, 32'h1000_0000 + 32'(i), 32'(i * 256), 32'(i), 1'b0);
      #1;
      check("t2_ready", 32'(bus.cmd_ready), (i <= 5) ? 32'd1 : 32'd0);
      check("t2_stall", 32'(bus.stall), (i == 6) ? 32'd1 : 32'd0);
      if (i == 3) begin
        check("t2_c2_accstart", 32'(bus.accstart), 32'd1);
        check("t2_c2_instrA",   bus.fullinstructionA, 32'h1000_0001);
      end
      if (i < 6) tick();
    end
    check("t2_c5_pending", 32'(bus.pending), 32'd4);
    tick();
    check("t2_c6_stall", 32'(bus.stall), 32'd1);
    tick();
    bus.accdone = 1'b1;
    #1;
    check("t2_c7_stall", 32'(bus.stall), 32'd1);
    tick();
    bus.accdone = 1'b0;
    check("t2_c8_stall", 32'(bus.stall), 32'd1);
    tick();
    check("t2_c9_stall",   32'(bus.stall), 32'd1);
    check("t2_c9_pending", 32'(bus.pending), 32'd4);
    check("t2_c9_done",    32'(bus.done_count), 32'd2);
    tick();
    check("t2_c10_stall",    32'(bus.stall), 32'd0);
    check("t2_c10_pending",  32'(bus.pending), 32'd3);
    check("t2_c10_accstart", 32'(bus.accstart), 32'd1);
    check("t2_c10_instrA",   bus.fullinstructionA, 32'h1000_0002);
    check("t2_c10_addrA",    bus.startaddrA, 32'h200);
    tick();
    set_cmd(1'b0, '0, '0, '0, 1'b0);
    bus.accdone = 1'b1;
    check("t2_c11_pending", 32'(bus.pending), 32'd4);
    for (int j = 3; j <= 6; j++) begin
      wait_accstart("t2_drain");
      check("t2_order_instr", bus.fullinstructionA, 32'h1000_0000 + 32'(j));
      check("t2_order_size",  bus.datasizeA, 32'(j));
      tick();
    end
    wait_idle("t2");
    bus.accdone = 1'b0;
    check("t2_done",    32'(bus.done_count), 32'd7);
    check("t2_pending", 32'(bus.pending), 32'd0);

    // Bypass job: IDLE pop at cycle 1, ISSUE 2, RETIRE 3, count visible at cycle 4
    set_cmd(1'b1, 32'hABCD_0000, 32'h80, 32'h20, 1'b1);
    tick();
    set_cmd(1'b0, '0, '0, '0, 1'b0);
    check("t3_c1_accstart", 32'(bus.accstart), 32'd0);
    tick();
    check("t3_c2_bypassA",  32'(bus.accbypassA), 32'd1);
    check("t3_c2_instrA",   bus.fullinstructionA, 32'hABCD_0000);
    check("t3_c2_accstart", 32'(bus.accstart), 32'd0);
    tick();
    check("t3_c3_accstart", 32'(bus.accstart), 32'd0);
    check("t3_c3_done",     32'(bus.done_count), 32'd7);
    tick();
    check("t3_c4_done", 32'(bus.done_count), 32'd8);
    check("t3_c4_busy", 32'(bus.busy), 32'd0);

    // Reset in WAIT with two jobs queued
    set_cmd(1'b1, 32'h2000_0001, 32'h1, 32'h1, 1'b0);
    tick();
    set_cmd(1'b1, 32'h2000_0002, 32'h2, 32'h2, 1'b0);
    tick();
    set_cmd(1'b1, 32'h2000_0003, 32'h3, 32'h3, 1'b0);
    check("t4_c2_accstart", 32'(bus.accstart), 32'd1);
    tick();
    set_cmd(1'b0, '0, '0, '0, 1'b0);
    check("t4_c3_pending", 32'(bus.pending), 32'd2);
    reset = 1'b0;
    tick();
    check("t4_pending",  32'(bus.pending), 32'd0);
    check("t4_busy",     32'(bus.busy), 32'd0);
    check("t4_instrA",   bus.fullinstructionA, 32'd0);
    check("t4_addrA",    bus.startaddrA, 32'd0);
    check("t4_sizeA",    bus.datasizeA, 32'd0);
    check("t4_done",     32'(bus.done_count), 32'd0);
    check("t4_accstart", 32'(bus.accstart), 32'd0);
    reset = 1'b1;
    tick();
    bus.accdone = 1'b1;
    tick();
    bus.accdone = 1'b0;
    tick();
    tick();
    check("t4_late_done",     32'(bus.done_count), 32'd0);
    check("t4_late_busy",     32'(bus.busy), 32'd0);
    check("t4_late_accstart", 32'(bus.accstart), 32'd0);

    // done_count wrap after 256 bypass retirements
    push_bypass(255);
    wait_idle("t5a");
    check("t5_done_255", 32'(bus.done_count), 32'd255);
    push_bypass(1);
    wait_idle("t5b");
    check("t5_done_wrap", 32'(bus.done_count), 32'd0);

`ifdef ACC_TIMEOUT_EN
    // Watchdog: WAIT cycles 3..10, timeout on the 8th with no accdone
    set_cmd(1'b1, 32'h3000_0001, 32'h0, 32'h4, 1'b0);
    tick();
    set_cmd(1'b0, '0, '0, '0, 1'b0);
    tick();
    repeat (8) tick();
    check("t6_c10_tmo", 32'(bus.timeout_err), 32'd0);
    tick();
    check("t6_c11_tmo",  32'(bus.timeout_err), 32'd1);
    check("t6_c11_done", 32'(bus.done_count), 32'd0);
    tick();
    check("t6_c12_done", 32'(bus.done_count), 32'd1);
    check("t6_c12_busy", 32'(bus.busy), 32'd0);
    repeat (3) tick();
    check("t6_sticky", 32'(bus.timeout_err), 32'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("t6_rst_tmo", 32'(bus.timeout_err), 32'd0);
    tick();
    set_cmd(1'b1, 32'h3000_0002, 32'h0, 32'h4, 1'b0);
    tick();
    set_cmd(1'b0, '0, '0, '0, 1'b0);
    tick();
    repeat (7) tick();
    bus.accdone = 1'b1;
    tick();
    bus.accdone = 1'b0;
    check("t6b_c11_tmo", 32'(bus.timeout_err), 32'd0);
    tick();
    check("t6b_c12_done", 32'(bus.done_count), 32'd1);
    check("t6b_c12_tmo",  32'(bus.timeout_err), 32'd0);
`else
    check("t6_tmo_tied", 32'(bus.timeout_err), 32'd0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
